// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: shared widths, fetch FSM states and opcode-format bit     |
// | Rev 1.0  initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int word_size    = 8;
  localparam int TWO_BYTE_BIT = 7;

  typedef enum logic [2:0] {
    REQ_OP   = 3'd0,
    WAIT_OP  = 3'd1,
`ifdef IF_TWO_BYTE_EN
    REQ_ARG  = 3'd2,
    WAIT_ARG = 3'd3,
`endif
    ISSUE    = 3'd4,
    REDIRECT = 3'd5
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +--------------------------------------------------------------------+
// | instruction_fetch: PC-driven fetch over req/ack, issue to decoder, |
// | branch redirect via load_pc. IF_TWO_BYTE_EN adds operand fetch.    |
// | Rev 1.0  initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module instruction_fetch
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] pc_count,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic [word_size-1:0] pc_d,
  output logic                 mem_req,
  output logic [word_size-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [word_size-1:0] mem_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [word_size-1:0] instr_opcode,
  output logic [word_size-1:0] instr_operand,
  input  logic                 branch_taken,
  input  logic [word_size-1:0] branch_target
);

  fetch_state_e         state_q;
  logic                 mem_req_q;
  logic [word_size-1:0] mem_addr_q;
  logic                 load_pc_q;
  logic [word_size-1:0] pc_d_q;
  logic                 valid_q;
  logic [word_size-1:0] opcode_q;
  logic                 pend_q;
  logic [word_size-1:0] tgt_q;

  logic                 waiting;
  logic                 redir_req;
  logic                 do_redir;
  logic [word_size-1:0] redir_tgt;

  always_comb begin
    waiting = (state_q == WAIT_OP);
`ifdef IF_TWO_BYTE_EN
    waiting = waiting || (state_q == WAIT_ARG);
`endif
  end

  // A same-cycle branch wins over the captured target so the newest one is used.
  assign redir_req = branch_taken || pend_q;
  assign redir_tgt = branch_taken ? branch_target : tgt_q;
  assign do_redir  = redir_req && (state_q != REDIRECT) && (!waiting || mem_ack);

  // The PC must advance on the ack edge itself, so inc_pc is decoded rather than registered.
  assign inc_pc = waiting && mem_ack && !redir_req;

`ifdef IF_TWO_BYTE_EN
  logic [word_size-1:0] operand_q;
  assign instr_operand = operand_q;
`else
  assign instr_operand = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ_OP;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      load_pc_q  <= 1'b0;
      pc_d_q     <= '0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      pend_q     <= 1'b0;
      tgt_q      <= '0;
`ifdef IF_TWO_BYTE_EN
      operand_q  <= '0;
`endif
    end else begin
      if (branch_taken) begin
        pend_q <= 1'b1;
        tgt_q  <= branch_target;
      end
      if (do_redir) begin
        pend_q    <= 1'b0;
        load_pc_q <= 1'b1;
        pc_d_q    <= redir_tgt;
        mem_req_q <= 1'b0;
        valid_q   <= 1'b0;
        state_q   <= REDIRECT;
      end else begin
        case (state_q)
          REQ_OP: begin
            mem_addr_q <= pc_count;
            mem_req_q  <= 1'b1;
            state_q    <= WAIT_OP;
          end
          WAIT_OP: begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              opcode_q  <= mem_data;
`ifdef IF_TWO_BYTE_EN
              if (mem_data[TWO_BYTE_BIT]) begin
                state_q <= REQ_ARG;
              end else begin
                operand_q <= '0;
                valid_q   <= 1'b1;
                state_q   <= ISSUE;
              end
`else
              valid_q <= 1'b1;
              state_q <= ISSUE;
`endif
            end
          end
`ifdef IF_TWO_BYTE_EN
          REQ_ARG: begin
            mem_addr_q <= pc_count;
            mem_req_q  <= 1'b1;
            state_q    <= WAIT_ARG;
          end
          WAIT_ARG: begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              operand_q <= mem_data;
              valid_q   <= 1'b1;
              state_q   <= ISSUE;
            end
          end
`endif
          ISSUE: begin
            if (instr_ready) begin
              valid_q <= 1'b0;
              state_q <= REQ_OP;
            end
          end
          REDIRECT: begin
            load_pc_q <= 1'b0;
            state_q   <= REQ_OP;
          end
          default: state_q <= REQ_OP;
        endcase
      end
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign load_pc      = load_pc_q;
  assign pc_d         = pc_d_q;
  assign instr_valid  = valid_q;
  assign instr_opcode = opcode_q;

endmodule

`default_nettype wire
